// File: rtl/stopwatch_counter.sv
// stopwatch_counter: multi-digit BCD stopwatch/timer with prescaler, up/down count, load and lap freeze
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start/stop/clear  one-cycle run control (clear > load > stop > start)
//   lap               one-cycle toggle of the frozen display
//   down, load,       count direction (latched on accepted start), load request
//   load_value        and packed BCD load data (clamped per digit)
//   digits_out        lap register while lap_active, else live digits
//   running, lap_active, tick, carry_out, done  status outputs, all registered
module stopwatch_counter #(
  parameter int TICK_DIV = 1000000,
  parameter int NUM_DIGITS = 6,
  parameter logic [NUM_DIGITS-1:0] MOD6_MASK = 6'b001010
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    clear,
  input  logic                    lap,
  input  logic                    down,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  output logic                    running,
  output logic                    lap_active,
  output logic                    tick,
  output logic                    carry_out,
  output logic                    done
);
  localparam int W = 4*NUM_DIGITS;
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV-1);
  logic [W-1:0] dig_q, dig_d, lap_q, lap_d, inc_v, dec_v, clamp_v;
  logic [PW-1:0] pre_q, pre_d;
  logic mode_q, mode_d, run_q, run_d, lapa_q, lapa_d;
  logic tick_q, tick_d, carry_q, carry_d, done_q, done_d, all_max;
  // Ripple enables: a digit steps when every lower digit is at max (up) or zero (down).
  always_comb begin : digit_logic
    logic u, w;
    logic [3:0] mx, cur, ld;
    u = 1'b1;
    w = 1'b1;
    mx = '0;
    cur = '0;
    ld = '0;
    inc_v = dig_q;
    dec_v = dig_q;
    clamp_v = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      mx = MOD6_MASK[i] ? 4'd5 : 4'd9;
      cur = dig_q[4*i +: 4];
      ld = load_value[4*i +: 4];
      inc_v[4*i +: 4] = u ? ((cur == mx) ? 4'd0 : cur + 4'd1) : cur;
      dec_v[4*i +: 4] = w ? ((cur == 4'd0) ? mx : cur - 4'd1) : cur;
      clamp_v[4*i +: 4] = (ld > mx) ? mx : ld;
      u = u & (cur == mx);
      w = w & (cur == 4'd0);
    end
    all_max = u;
  end
  always_comb begin
    dig_d = dig_q;
    lap_d = lap_q;
    pre_d = pre_q;
    mode_d = mode_q;
    run_d = run_q;
    lapa_d = lapa_q;
    tick_d = 1'b0;
    carry_d = 1'b0;
    done_d = done_q;
    // Lap samples dig_q, so a coincident tick leaves the pre-tick value in the lap register.
    if (lap) begin
      lapa_d = ~lapa_q;
      lap_d = lapa_q ? lap_q : dig_q;
    end
    if (clear) begin
      dig_d = '0;
      pre_d = '0;
      lapa_d = 1'b0;
      done_d = 1'b0;
      run_d = 1'b0;
    end else if (load && !run_q) begin
      dig_d = clamp_v;
      pre_d = '0;
      done_d = 1'b0;
    end else if (stop) begin
      run_d = 1'b0;
    end else if (start && !run_q) begin
      // A countdown from zero is refused and reported as already done.
      run_d = !(down && dig_q == '0);
      mode_d = (down && dig_q == '0) ? mode_q : down;
      done_d = down && dig_q == '0;
    end else if (run_q) begin
      pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
      if (pre_q == PRE_LAST) begin
        tick_d = 1'b1;
        dig_d = mode_q ? dec_v : inc_v;
        carry_d = !mode_q && all_max;
        done_d = mode_q && dec_v == '0;
        run_d = !(mode_q && dec_v == '0);
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig_q <= '0;
      lap_q <= '0;
      pre_q <= '0;
      mode_q <= 1'b0;
      run_q <= 1'b0;
      lapa_q <= 1'b0;
      tick_q <= 1'b0;
      carry_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      dig_q <= dig_d;
      lap_q <= lap_d;
      pre_q <= pre_d;
      mode_q <= mode_d;
      run_q <= run_d;
      lapa_q <= lapa_d;
      tick_q <= tick_d;
      carry_q <= carry_d;
      done_q <= done_d;
    end
  end
  assign digits_out = lapa_q ? lap_q : dig_q;
  assign running = run_q;
  assign lap_active = lapa_q;
  assign tick = tick_q;
  assign carry_out = carry_q;
  assign done = done_q;
endmodule

// File: tb/tb_stopwatch_counter.sv
// tb_stopwatch_counter: vector table, directed corner sequences and random run against a value-level model
module tb_stopwatch_counter;
  localparam int TD = 4;
  localparam int ND = 3;
  localparam logic [5:0] I = 6'b000000, S = 6'b100000, P = 6'b010000, C = 6'b001000;
  localparam logic [5:0] L = 6'b000100, D = 6'b000010, LD = 6'b000001;
  localparam logic [4:0] E_R = 5'b10000, E_A = 5'b01000, E_T = 5'b00100, E_D = 5'b00001;
  typedef struct {
    logic [5:0]  ctl;
    logic [11:0] lv;
    logic [11:0] dig;
    logic [4:0]  exp;
  } vec_t;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0;
  logic lap = 1'b0, down = 1'b0, load = 1'b0;
  logic [11:0] load_value = '0, digits_out;
  logic running, lap_active, tick, carry_out, done;
  int n_chk = 0, n_fail = 0;
  int m_cnt, m_pre, m_lapv;
  bit m_run, m_mode, m_done, m_lapa, m_tick, m_carry;
  vec_t vt[$];
  always #5 clk = ~clk;
  stopwatch_counter #(.TICK_DIV(TD), .NUM_DIGITS(ND), .MOD6_MASK(3'b010)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .lap(lap),
    .down(down), .load(load), .load_value(load_value), .digits_out(digits_out),
    .running(running), .lap_active(lap_active), .tick(tick), .carry_out(carry_out),
    .done(done)
  );
  function automatic logic [11:0] bcd(int n);
    return {4'(n / 60), 4'((n / 10) % 6), 4'(n % 10)};
  endfunction
  function automatic int clampv(logic [11:0] v);
    int d0, d1, d2;
    d0 = (v[3:0] > 9) ? 9 : int'(v[3:0]);
    d1 = (v[7:4] > 5) ? 5 : int'(v[7:4]);
    d2 = (v[11:8] > 9) ? 9 : int'(v[11:8]);
    return d2 * 60 + d1 * 10 + d0;
  endfunction
  function automatic vec_t mk(logic [5:0] c, logic [11:0] v, logic [11:0] d, logic [4:0] e);
    vec_t r;
    r.ctl = c;
    r.lv = v;
    r.dig = d;
    r.exp = e;
    return r;
  endfunction
  task automatic model_reset();
    m_cnt = 0; m_pre = 0; m_lapv = 0;
    m_run = 0; m_mode = 0; m_done = 0; m_lapa = 0; m_tick = 0; m_carry = 0;
  endtask
  // Count held as a plain integer 0..599 (digit weights 60/10/1).
  task automatic model_step();
    m_tick = 0;
    m_carry = 0;
    if (lap) begin
      if (m_lapa) m_lapa = 0;
      else begin
        m_lapv = m_cnt;
        m_lapa = 1;
      end
    end
    if (clear) begin
      m_cnt = 0; m_pre = 0; m_lapa = 0; m_done = 0; m_run = 0;
    end else if (load && !m_run) begin
      m_cnt = clampv(load_value); m_pre = 0; m_done = 0;
    end else if (stop) begin
      m_run = 0;
    end else if (start && !m_run) begin
      if (down && m_cnt == 0) m_done = 1;
      else begin
        m_mode = down; m_run = 1; m_done = 0;
      end
    end else if (m_run) begin
      m_pre = m_pre + 1;
      if (m_pre == TD) begin
        m_pre = 0;
        m_tick = 1;
        if (!m_mode) begin
          m_carry = (m_cnt == 599);
          m_cnt = (m_cnt + 1) % 600;
        end else begin
          m_cnt = m_cnt - 1;
          if (m_cnt == 0) begin
            m_done = 1; m_run = 0;
          end
        end
      end
    end
  endtask
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    {start, stop, clear, lap, load} = '0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #2;
    chk("async_rst", {digits_out, running, lap_active, tick, carry_out, done}, '0);
    rst = 1'b0;
  endtask
  task automatic do_start(logic dn);
    down = dn;
    start = 1'b1;
    step();
    down = 1'b0;
  endtask
  initial begin
    #1;
    do_reset();
    // Table: one row per cycle, expected {digits, running, lap_active, tick, carry, done}.
    vt.push_back(mk(LD,     12'h08F, 12'h059, 5'b0));
    vt.push_back(mk(S | P,  12'h000, 12'h059, 5'b0));
    vt.push_back(mk(C | LD, 12'h123, 12'h000, 5'b0));
    vt.push_back(mk(LD,     12'h123, 12'h123, 5'b0));
    vt.push_back(mk(S,      12'h000, 12'h123, E_R));
    vt.push_back(mk(LD,     12'h456, 12'h123, E_R));
    vt.push_back(mk(I,      12'h000, 12'h123, E_R));
    vt.push_back(mk(L,      12'h000, 12'h123, E_R | E_A));
    vt.push_back(mk(I,      12'h000, 12'h123, E_R | E_A | E_T));
    vt.push_back(mk(L,      12'h000, 12'h124, E_R));
    vt.push_back(mk(S,      12'h000, 12'h124, E_R));
    vt.push_back(mk(P,      12'h000, 12'h124, 5'b0));
    vt.push_back(mk(C,      12'h000, 12'h000, 5'b0));
    vt.push_back(mk(S | D,  12'h000, 12'h000, E_D));
    vt.push_back(mk(LD,     12'h002, 12'h002, 5'b0));
    vt.push_back(mk(S | D,  12'h000, 12'h002, E_R));
    for (int k = 0; k < 3; k++) vt.push_back(mk(I, 12'h000, 12'h002, E_R));
    vt.push_back(mk(I,      12'h000, 12'h001, E_R | E_T));
    for (int k = 0; k < 3; k++) vt.push_back(mk(I, 12'h000, 12'h001, E_R));
    vt.push_back(mk(I,      12'h000, 12'h000, E_T | E_D));
    vt.push_back(mk(I,      12'h000, 12'h000, E_D));
    foreach (vt[i]) begin
      {start, stop, clear, lap, down, load} = vt[i].ctl;
      load_value = vt[i].lv;
      step();
      chk($sformatf("vec%0d", i), {digits_out, running, lap_active, tick, carry_out, done},
          {vt[i].dig, vt[i].exp});
    end
    down = 1'b0;
    // Up count from zero: tick every 4 cycles, 010 after 40, then async reset mid-count.
    do_reset();
    do_start(1'b0);
    chk("up_run", running, 1);
    for (int j = 1; j <= 40; j++) begin
      step();
      chk($sformatf("up%0d", j), {digits_out, tick}, {bcd(j / TD), j % TD == 0});
    end
    do_reset();
    // All-max wrap.
    load_value = 12'h959; load = 1'b1; step();
    do_start(1'b0);
    repeat (4) step();
    chk("wrap", {digits_out, carry_out, running}, {12'h000, 2'b11});
    step();
    chk("wrap_pulse", {digits_out, carry_out, running}, {12'h000, 2'b01});
    // Countdown with borrow, then to zero, hold, refused restart.
    do_reset();
    load_value = 12'h100; load = 1'b1; step();
    do_start(1'b1);
    repeat (4) step();
    chk("borrow", digits_out, 12'h059);
    stop = 1'b1; step();
    load_value = 12'h002; load = 1'b1; step();
    do_start(1'b1);
    repeat (4) step();
    chk("dn1", {digits_out, running, done}, {12'h001, 2'b10});
    repeat (4) step();
    chk("dn0", {digits_out, running, done}, {12'h000, 2'b01});
    repeat (20) step();
    chk("dn_hold", {digits_out, running, done, tick}, {12'h000, 3'b010});
    do_start(1'b1);
    chk("dn_refuse", {running, done}, 2'b01);
    // Lap freeze while running.
    do_reset();
    do_start(1'b0);
    repeat (12) step();
    chk("lap_pre", digits_out, 12'h003);
    lap = 1'b1; step();
    chk("lap_on", {digits_out, lap_active}, {12'h003, 1'b1});
    repeat (15) step();
    chk("lap_frozen", {digits_out, lap_active, running}, {12'h003, 2'b11});
    lap = 1'b1; step();
    chk("lap_off", {digits_out, lap_active}, {12'h007, 1'b0});
    // Stop mid-period resumes the partial period.
    do_reset();
    do_start(1'b0);
    repeat (2) step();
    stop = 1'b1; step();
    chk("stop", running, 0);
    repeat (10) step();
    chk("stopped", {digits_out, running, tick}, '0);
    do_start(1'b0);
    chk("resume", running, 1);
    step();
    chk("resume1", {digits_out, tick}, '0);
    step();
    chk("resume2", {digits_out, tick}, {12'h001, 1'b1});
    // Random run against the integer model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      start = ($urandom_range(0, 7) == 0);
      stop = ($urandom_range(0, 31) == 0);
      clear = ($urandom_range(0, 63) == 0);
      lap = ($urandom_range(0, 15) == 0);
      load = ($urandom_range(0, 15) == 0);
      down = 1'($urandom_range(0, 1));
      load_value = ($urandom_range(0, 3) == 0) ? 12'h959 : 12'($urandom);
      step();
      chk($sformatf("rnd%0d", n), {digits_out, running, lap_active, tick, carry_out, done},
          {m_lapa ? bcd(m_lapv) : bcd(m_cnt), m_run, m_lapa, m_tick, m_carry, m_done});
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
